// File: rtl/fmul_seq_pkg.sv
// Shared types and mode helpers for the sequential fractional multiplier.
package fmul_seq_pkg;

  typedef enum logic [1:0] {
    MODE_MUL    = 2'b00,
    MODE_FMUL   = 2'b01,
    MODE_FMULS  = 2'b10,
    MODE_FMULSU = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_SIGN,
    ST_DONE
  } state_t;

  function automatic logic is_signed_rd(mode_t mode);
    return (mode == MODE_FMULS) || (mode == MODE_FMULSU);
  endfunction

  function automatic logic is_signed_rr(mode_t mode);
    return (mode == MODE_FMULS);
  endfunction

endpackage

// File: rtl/fmul_sign_cond.sv
// Operand conditioning: splits a possibly-signed operand into sign and magnitude.
module fmul_sign_cond #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_op,
  input  logic             i_signed,
  output logic [WIDTH-1:0] o_mag,
  output logic             o_sign
);

  // The most negative value maps to itself, which reads correctly as an unsigned magnitude.
  assign o_sign = i_signed & i_op[WIDTH-1];
  assign o_mag  = o_sign ? (~i_op + 1'b1) : i_op;

endmodule

// File: rtl/fmul_seq.sv
// Radix-2 shift-add multiplier with MUL/FMUL/FMULS/FMULSU modes and valid/ready handshakes.
// Optional macro FMUL_SEQ_EARLY_TERM_EN: leave CALC once the remaining multiplier bits are zero.
module fmul_seq
  import fmul_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [1:0]       i_mode,
  input  logic [WIDTH-1:0] i_rd,
  input  logic [WIDTH-1:0] i_rr,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_r1,
  output logic [WIDTH-1:0] o_r0,
  output logic             o_c,
  output logic             o_z
);

  state_t               r_state, w_state_d;
  mode_t                r_mode;
  logic [WIDTH-1:0]     r_mcand, r_mplier;
  logic [2*WIDTH-1:0]   r_acc;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_neg;
  logic [WIDTH-1:0]     r_r1, r_r0;
  logic                 r_c, r_z;

  logic [WIDTH-1:0]     w_rd_mag, w_rr_mag;
  logic                 w_rd_sign, w_rr_sign;
  logic                 w_accept, w_calc_last;
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_acc_fin, w_p, w_res;

  fmul_sign_cond #(.WIDTH(WIDTH)) u_cond_rd (
    .i_op     (i_rd),
    .i_signed (is_signed_rd(mode_t'(i_mode))),
    .o_mag    (w_rd_mag),
    .o_sign   (w_rd_sign)
  );

  fmul_sign_cond #(.WIDTH(WIDTH)) u_cond_rr (
    .i_op     (i_rr),
    .i_signed (is_signed_rr(mode_t'(i_mode))),
    .o_mag    (w_rr_mag),
    .o_sign   (w_rr_sign)
  );

  assign w_accept = i_valid & o_ready;
  assign w_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_mplier[0] ? r_mcand : '0)};

`ifdef FMUL_SEQ_EARLY_TERM_EN
  assign w_calc_last = (r_cnt == CNT_W'(WIDTH - 1)) || (r_mplier[WIDTH-1:1] == '0);
  // Skipped iterations would only shift zeros in, so apply the missing shifts at once.
  assign w_acc_fin   = r_acc >> (CNT_W'(WIDTH) - r_cnt);
`else
  assign w_calc_last = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_acc_fin   = r_acc;
`endif

  assign w_p   = r_neg ? (~w_acc_fin + 1'b1) : w_acc_fin;
  assign w_res = (r_mode == MODE_MUL) ? w_p : {w_p[2*WIDTH-2:0], 1'b0};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    o_ready   = 1'b0;
    o_valid   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        o_ready = 1'b1;
        if (i_valid) w_state_d = ST_CALC;
      end
      ST_CALC: if (w_calc_last) w_state_d = ST_SIGN;
      ST_SIGN: w_state_d = ST_DONE;
      ST_DONE: begin
        o_valid = 1'b1;
        if (i_ready) w_state_d = ST_IDLE;
      end
      default: w_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mode   <= MODE_MUL;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_r1     <= '0;
      r_r0     <= '0;
      r_c      <= 1'b0;
      r_z      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_mode   <= mode_t'(i_mode);
        r_mcand  <= w_rd_mag;
        r_mplier <= w_rr_mag;
        r_neg    <= w_rd_sign ^ w_rr_sign;
        r_acc    <= '0;
        r_cnt    <= '0;
      end else if (r_state == ST_CALC) begin
        r_acc    <= {w_sum, r_acc[WIDTH-1:1]};
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + 1'b1;
      end else if (r_state == ST_SIGN) begin
        r_c  <= w_p[2*WIDTH-1];
        r_r1 <= w_res[2*WIDTH-1:WIDTH];
        r_r0 <= w_res[WIDTH-1:0];
        r_z  <= (w_res == '0);
      end
    end
  end

  assign o_r1 = r_r1;
  assign o_r0 = r_r0;
  assign o_c  = r_c;
  assign o_z  = r_z;

endmodule

// File: tb/tb_fmul_seq.sv
// Directed self-checking bench for fmul_seq at WIDTH=8.
module tb_fmul_seq;

  logic       clk, rst;
  logic       i_valid, o_ready, o_valid, i_ready;
  logic [1:0] i_mode;
  logic [7:0] i_rd, i_rr, o_r1, o_r0;
  logic       o_c, o_z;

  int n_checks = 0;
  int n_fail   = 0;

  fmul_seq #(.WIDTH(8)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_mode  (i_mode),
    .i_rd    (i_rd),
    .i_rr    (i_rr),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_r1    (o_r1),
    .o_r0    (o_r0),
    .o_c     (o_c),
    .o_z     (o_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected edges from accept to o_valid.
  function automatic int exp_lat(input logic [1:0] mode, input logic [7:0] rr);
    logic [7:0] mag;
    int n;
    mag = (mode == 2'b10 && rr[7]) ? (~rr + 8'd1) : rr;
    n = 1;
    for (int b = 0; b < 8; b++) if (mag[b]) n = b + 1;
`ifdef FMUL_SEQ_EARLY_TERM_EN
    return n + 1;
`else
    return 9;
`endif
  endfunction

  // Runs one operation; optionally injects a stray i_valid during CALC and applies backpressure.
  task automatic run_op(input string tag, input logic [1:0] mode, input logic [7:0] rd,
                        input logic [7:0] rr, input logic [7:0] e1, input logic [7:0] e0,
                        input logic ec, input logic ez, input bit inject, input int hold);
    int lat;
    @(negedge clk);
    check({tag, ".ready"}, {31'd0, o_ready}, 32'd1);
    i_mode = mode; i_rd = rd; i_rr = rr; i_valid = 1'b1;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
      if (o_valid) break;
      if (inject && lat == 3) begin
        i_mode = 2'b00; i_rd = 8'h12; i_rr = 8'h34; i_valid = 1'b1;
      end else begin
        i_valid = 1'b0;
      end
    end
    i_valid = 1'b0;
    check({tag, ".lat"}, lat, exp_lat(mode, rr));
    for (int h = 0; h <= hold; h++) begin
      @(negedge clk);
      check({tag, ".r1"}, {24'd0, o_r1}, {24'd0, e1});
      check({tag, ".r0"}, {24'd0, o_r0}, {24'd0, e0});
      check({tag, ".cz"}, {30'd0, o_c, o_z}, {30'd0, ec, ez});
      if (hold > 0) check({tag, ".hold"}, {30'd0, o_valid, o_ready}, 32'd2);
    end
    i_ready = 1'b1;
    @(posedge clk);
    #1;
    i_ready = 1'b0;
    check({tag, ".released"}, {31'd0, o_valid}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_mode = 2'b00; i_rd = '0; i_rr = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.hs", {30'd0, o_ready, o_valid}, 32'd2);
    check("rst.res", {14'd0, o_r1, o_r0, o_c, o_z}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("mul",      2'b00, 8'h0F, 8'h11, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 0);
    run_op("fmul_ff",  2'b01, 8'hFF, 8'hFF, 8'hFC, 8'h02, 1'b1, 1'b0, 1'b1, 0);
    run_op("fmul_80",  2'b01, 8'h80, 8'h80, 8'h80, 8'h00, 1'b0, 1'b0, 1'b0, 0);
    run_op("fmuls_c0", 2'b10, 8'hC0, 8'h40, 8'hE0, 8'h00, 1'b1, 1'b0, 1'b0, 5);
    run_op("fmuls_80", 2'b10, 8'h80, 8'h80, 8'h80, 8'h00, 1'b0, 1'b0, 1'b0, 0);
    run_op("fmulsu",   2'b11, 8'hFF, 8'hFF, 8'hFE, 8'h02, 1'b1, 1'b0, 1'b0, 0);
    run_op("fmul_0",   2'b01, 8'h00, 8'hAB, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 0);
    run_op("mul_55",   2'b00, 8'h55, 8'h01, 8'h00, 8'h55, 1'b0, 1'b0, 1'b0, 0);
    run_op("fmul_pre", 2'b01, 8'hFF, 8'hFF, 8'hFC, 8'h02, 1'b1, 1'b0, 1'b0, 0);

    // Abort mid-CALC; previous result outputs are nonzero so clearing is observable.
    @(negedge clk);
    i_mode = 2'b00; i_rd = 8'h0F; i_rr = 8'hFF; i_valid = 1'b1;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort.hs", {30'd0, o_ready, o_valid}, 32'd2);
    check("abort.res", {14'd0, o_r1, o_r0, o_c, o_z}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("post_rst", 2'b10, 8'hC0, 8'hC0, 8'h20, 8'h00, 1'b0, 1'b0, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
